// File: rtl/spi_master.sv
// SPI bus master, mode 1 (CPOL=0, CPHA=1), MSB first.
// Bridges one AXI-stream tx word to one full-duplex SPI frame and returns the rx word.
module spi_master #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned DATA_LEN = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_LEN-1:0] tx_tdata,
   input  logic                tx_tvalid,
   output logic                tx_tready,
   output logic [DATA_LEN-1:0] rx_tdata,
   output logic                rx_tvalid,
   input  logic                rx_tready,
   output logic                busy,
   output logic                spi_sclk,
   output logic                spi_mosi,
   input  logic                spi_miso,
   output logic                spi_cs_n
);

   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam int unsigned CW = $clog2(DATA_LEN) + 1;
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD,
      S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       div_q, div_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_LEN-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_LEN-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_LEN-1:0] rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                tx_ready_q, tx_ready_d;
   logic                busy_q, busy_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                cs_n_q, cs_n_d;
   logic                div_done;
   logic                start;
   logic [CW-1:0]       cnt_inc;

   assign div_done = (div_q == '0);
   assign cnt_inc  = cnt_q + CW'(1);
   assign start    = tx_tvalid & tx_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      busy_d     = busy_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;

      if (rx_valid_q && rx_tready) begin
         rx_valid_d = 1'b0;
      end

      if (state_q != S_IDLE) begin
         div_d = div_done ? DIV_LOAD : div_q - DW'(1);
      end

      if (div_done) begin
         case (state_q)
            S_SETUP: begin
               sclk_d  = 1'b1;
               state_d = S_HIGH;
            end
            S_HIGH: begin
               sclk_d     = 1'b0;
               rx_shift_d = {rx_shift_q[DATA_LEN-2:0], spi_miso};
               cnt_d      = cnt_inc;
               state_d    = (cnt_inc == CW'(DATA_LEN)) ? S_HOLD : S_LOW;
            end
            S_LOW: begin
               sclk_d     = 1'b1;
               tx_shift_d = {tx_shift_q[DATA_LEN-2:0], 1'b0};
               mosi_d     = tx_shift_q[DATA_LEN-2];
               state_d    = S_HIGH;
            end
            S_HOLD: begin
               cs_n_d     = 1'b1;
               mosi_d     = 1'b0;
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               state_d    = S_GAP;
            end
            S_GAP: begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: ;
         endcase
      end

      // Accept also on the last GAP cycle so back-to-back frames keep cs_n high for exactly CLK_DIV cycles.
      if (start) begin
         tx_shift_d = tx_tdata;
         rx_shift_d = '0;
         cnt_d      = '0;
         busy_d     = 1'b1;
         cs_n_d     = 1'b0;
         sclk_d     = 1'b0;
         mosi_d     = tx_tdata[DATA_LEN-1];
         div_d      = DIV_LOAD;
         state_d    = S_SETUP;
      end

      tx_ready_d = ~rx_valid_d &
                   ((state_d == S_IDLE) || ((state_d == S_GAP) && (div_d == '0)));
   end

   assign tx_tready = tx_ready_q;
   assign rx_tdata  = rx_data_q;
   assign rx_tvalid = rx_valid_q;
   assign busy      = busy_q;
   assign spi_sclk  = sclk_q;
   assign spi_mosi  = mosi_q;
   assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table-driven frames with a scoreboard,
// plus hand sequences for backpressure, back-to-back, mid-frame reset and a 16-bit build.
module tb_spi_master;

   localparam int A_DIV = 4;
   localparam int A_LEN = 8;
   localparam int A_CSLOW = A_DIV * (2 * A_LEN + 1);
   localparam int A_LAT = A_CSLOW + 1;
   localparam logic [7:0] SLAVE_WORD = 8'h3C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   // DUT A: defaults
   logic [7:0] a_tx_tdata, a_rx_tdata;
   logic a_tx_tvalid, a_tx_tready, a_rx_tvalid, a_rx_tready, a_busy;
   logic a_sclk, a_mosi, a_miso, a_cs_n;

   // DUT B: 16-bit, fastest divider, loopback
   logic [15:0] b_tx_tdata, b_rx_tdata;
   logic b_tx_tvalid, b_tx_tready, b_rx_tvalid, b_rx_tready, b_busy;
   logic b_sclk, b_mosi, b_cs_n;

   int   mode;          // 0 loopback, 1 slave model, 2 loopback with noise while sclk low
   logic noise = 1'b0;
   logic s_miso = 1'b0;
   logic [7:0] s_tx = '0;
   logic [7:0] s_rx = '0;

   assign a_miso = (mode == 1) ? s_miso : ((mode == 2) && !a_sclk) ? noise : a_mosi;

   spi_master #(.CLK_DIV(A_DIV), .DATA_LEN(A_LEN)) u_dut_a (
      .clk(clk), .rst(rst),
      .tx_tdata(a_tx_tdata), .tx_tvalid(a_tx_tvalid), .tx_tready(a_tx_tready),
      .rx_tdata(a_rx_tdata), .rx_tvalid(a_rx_tvalid), .rx_tready(a_rx_tready),
      .busy(a_busy), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso),
      .spi_cs_n(a_cs_n)
   );

   spi_master #(.CLK_DIV(2), .DATA_LEN(16)) u_dut_b (
      .clk(clk), .rst(rst),
      .tx_tdata(b_tx_tdata), .tx_tvalid(b_tx_tvalid), .tx_tready(b_tx_tready),
      .rx_tdata(b_rx_tdata), .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready),
      .busy(b_busy), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_mosi),
      .spi_cs_n(b_cs_n)
   );

   // Mode-1 slave peer: shifts out on rising sclk, captures mosi on falling sclk.
   always @(negedge a_cs_n) s_tx = SLAVE_WORD;
   always @(posedge a_sclk) if (!a_cs_n) begin
      s_miso = s_tx[7];
      s_tx   = {s_tx[6:0], 1'b0};
   end
   always @(negedge a_sclk) if (!a_cs_n) s_rx = {s_rx[6:0], a_mosi};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=timeout required=event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard, sampled on the falling clk edge
   logic [7:0] sb[$];
   int   gaps[$];
   int   acc_cyc = 0;
   bit   have_acc = 1'b0;
   bit   prev_cs = 1'b1, prev_sclk = 1'b0, prev_rxv = 1'b0;
   int   cs_lo = 0, cs_hi = 0, rises = 0;
   logic [7:0] bits = '0;

   always @(negedge clk) begin
      noise = 1'($urandom_range(0, 1));
      if (rst) begin
         sb.delete();
         have_acc = 1'b0;
         prev_cs = 1'b1; prev_sclk = 1'b0; prev_rxv = 1'b0;
         cs_lo = 0; cs_hi = 0; rises = 0; bits = '0;
      end else begin
         if (a_tx_tvalid && a_tx_tready) begin
            sb.push_back((mode == 1) ? SLAVE_WORD : a_tx_tdata);
            acc_cyc = cyc;
            have_acc = 1'b1;
         end
         if (a_rx_tvalid && !prev_rxv && have_acc)
            check("rx_latency", 32'(cyc - acc_cyc), 32'(A_LAT));
         if (a_rx_tvalid && a_rx_tready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: actual=0x%0h required=none", a_rx_tdata);
            end else begin
               check("sb_rx", 32'(a_rx_tdata), 32'(sb.pop_front()));
            end
         end
         if (!a_cs_n) cs_lo++; else cs_hi++;
         if (prev_cs && !a_cs_n) begin
            gaps.push_back(cs_hi);
            cs_hi = 0; rises = 0; bits = '0;
         end
         if (!prev_cs && a_cs_n) begin
            check("cs_low_time", 32'(cs_lo), 32'(A_CSLOW));
            cs_lo = 0;
         end
         if (a_sclk && !prev_sclk) begin
            rises++;
            bits = {bits[6:0], a_mosi};
         end
         prev_cs = a_cs_n; prev_sclk = a_sclk; prev_rxv = a_rx_tvalid;
      end
   end

   task automatic send_a(input logic [7:0] d);
      a_tx_tdata  = d;
      a_tx_tvalid = 1'b1;
      for (int n = 0; n < 400 && !a_tx_tready; n++) tick();
      if (!a_tx_tready) timeout("tx_accept");
      tick();
      a_tx_tvalid = 1'b0;
   endtask

   task automatic wait_rx_a();
      for (int n = 0; n < 400 && !a_rx_tvalid; n++) tick();
      if (!a_rx_tvalid) timeout("rx_valid");
   endtask

   task automatic wait_idle_a();
      for (int n = 0; n < 400 && a_busy; n++) tick();
      if (a_busy) timeout("busy_clear");
   endtask

   typedef struct {
      logic [7:0] tx;
      int         mode;
      logic [7:0] exp_rx;
   } vec_t;
   vec_t vecs[5];

   initial begin
      bit seen, seen_cs;
      int falls, lo, rs;
      bit pv;

      vecs[0] = '{8'hA5, 0, 8'hA5};
      vecs[1] = '{8'hC3, 1, 8'h3C};
      vecs[2] = '{8'h00, 0, 8'h00};
      vecs[3] = '{8'hFF, 0, 8'hFF};
      vecs[4] = '{8'h96, 2, 8'h96};

      rst = 1'b1; mode = 0;
      a_tx_tdata = '0; a_tx_tvalid = 1'b0; a_rx_tready = 1'b1;
      b_tx_tdata = '0; b_tx_tvalid = 1'b0; b_rx_tready = 1'b1;
      repeat (3) tick();
      check("rst_sclk", 32'(a_sclk), 32'(0));
      check("rst_cs_n", 32'(a_cs_n), 32'(1));
      check("rst_mosi", 32'(a_mosi), 32'(0));
      check("rst_rx_tdata", 32'(a_rx_tdata), 32'(0));
      check("rst_rx_tvalid", 32'(a_rx_tvalid), 32'(0));
      check("rst_busy", 32'(a_busy), 32'(0));
      check("rst_tx_tready", 32'(a_tx_tready), 32'(1));
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         mode = vecs[i].mode;
         send_a(vecs[i].tx);
         wait_rx_a();
         check("tbl_rx", 32'(a_rx_tdata), 32'(vecs[i].exp_rx));
         wait_idle_a();
         check("tbl_mosi_bits", 32'(bits), 32'(vecs[i].tx));
         check("tbl_rises", 32'(rises), 32'(A_LEN));
         if (vecs[i].mode == 1) check("slave_rx", 32'(s_rx), 32'(vecs[i].tx));
         tick();
      end
      mode = 0;

      // Backpressure: a completed word blocks the next frame until consumed
      a_rx_tready = 1'b0;
      send_a(8'h11);
      wait_rx_a();
      a_tx_tdata = 8'h22; a_tx_tvalid = 1'b1;
      seen = 1'b0; seen_cs = 1'b0;
      for (int n = 0; n < 120; n++) begin
         tick();
         if (a_tx_tready) seen = 1'b1;
         if (!a_cs_n) seen_cs = 1'b1;
      end
      check("bp_tx_tready_low", 32'(seen), 32'(0));
      check("bp_cs_n_high", 32'(seen_cs), 32'(0));
      check("bp_rx_held", 32'(a_rx_tdata), 32'h11);
      check("bp_rx_valid_held", 32'(a_rx_tvalid), 32'(1));
      a_rx_tready = 1'b1;
      tick();
      check("bp_rx_consumed", 32'(a_rx_tvalid), 32'(0));
      check("bp_tx_ready", 32'(a_tx_tready), 32'(1));
      check("bp_cs_still_high", 32'(a_cs_n), 32'(1));
      tick();
      a_tx_tvalid = 1'b0;
      check("bp_frame2_cs_low", 32'(a_cs_n), 32'(0));
      check("bp_frame2_busy", 32'(a_busy), 32'(1));
      wait_rx_a();
      check("bp_rx2", 32'(a_rx_tdata), 32'h22);
      wait_idle_a();
      tick();

      // Back-to-back frames with tx_tvalid held
      gaps.delete();
      a_tx_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_tx_tdata = 8'(i + 1);
         for (int n = 0; n < 400 && !a_tx_tready; n++) tick();
         if (!a_tx_tready) timeout("b2b_accept");
         tick();
      end
      a_tx_tvalid = 1'b0;
      wait_rx_a();
      wait_idle_a();
      check("b2b_frames", 32'(gaps.size()), 32'(3));
      if (gaps.size() == 3) begin
         check("b2b_gap1", 32'(gaps[1]), 32'(A_DIV));
         check("b2b_gap2", 32'(gaps[2]), 32'(A_DIV));
      end
      tick();

      // Reset after the 3rd falling sclk edge
      send_a(8'hE7);
      falls = 0;
      pv = a_sclk;
      for (int n = 0; n < 400 && falls < 3; n++) begin
         tick();
         if (pv && !a_sclk) falls++;
         pv = a_sclk;
      end
      if (falls < 3) timeout("rst_falls");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_cs_n", 32'(a_cs_n), 32'(1));
      check("mrst_sclk", 32'(a_sclk), 32'(0));
      check("mrst_mosi", 32'(a_mosi), 32'(0));
      check("mrst_tx_tready", 32'(a_tx_tready), 32'(1));
      check("mrst_busy", 32'(a_busy), 32'(0));
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (a_rx_tvalid) seen = 1'b1;
      end
      check("mrst_no_rx_valid", 32'(seen), 32'(0));
      send_a(8'h5A);
      wait_rx_a();
      check("mrst_next_rx", 32'(a_rx_tdata), 32'h5A);
      wait_idle_a();
      tick();

      // 16-bit loopback on DUT B
      b_tx_tdata = 16'h8001; b_tx_tvalid = 1'b1;
      for (int n = 0; n < 100 && !b_tx_tready; n++) tick();
      tick();
      b_tx_tvalid = 1'b0;
      lo = 0; rs = 0; pv = 1'b0;
      for (int n = 0; n < 400 && !b_rx_tvalid; n++) begin
         if (!b_cs_n) lo++;
         if (b_sclk && !pv) rs++;
         pv = b_sclk;
         tick();
      end
      if (!b_rx_tvalid) timeout("b_rx_valid");
      check("b_rx", 32'(b_rx_tdata), 32'h8001);
      check("b_cs_low", 32'(lo), 32'(66));
      check("b_rises", 32'(rs), 32'(16));

      repeat (10) tick();
      check("sb_empty", 32'(sb.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI bus master (mode 1: CPOL=0, CPHA=1, MSB first) that drives spi_sclk, spi_cs_n and spi_mosi, and samples spi_miso.
- Bridges one AXI-stream input word to one full-duplex SPI frame, and returns the received word on an AXI-stream output.
- Initiator counterpart of spi_slave; used on-chip to talk to spi_slave instances and external SPI peripherals.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles. Legal range ≥2. For an spi_slave peer, must be ≥4× the peer's clk period ratio.
- DATA_LEN, 8: bits per frame. Legal range ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tx_tdata  input  DATA_LEN  word to transmit
- tx_tvalid  input  1  tx word valid
- tx_tready  output  1  master accepts a tx word
- rx_tdata  output  DATA_LEN  word received on miso
- rx_tvalid  output  1  rx word valid
- rx_tready  input  1  downstream accepts rx word
- busy  output  1  high from accept until return to IDLE
- spi_sclk  output  1  serial clock, idles low
- spi_mosi  output  1  master data out
- spi_miso  input  1  slave data in
- spi_cs_n  output  1  chip select, active low

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Registered outputs: all outputs are registered.
- Values on the cycle after a reset edge: spi_sclk=0, spi_cs_n=1, spi_mosi=0, rx_tdata=0, rx_tvalid=0, busy=0, tx_tready=1.
- Reset mid-frame: reset aborts any frame immediately. cs_n returns high, sclk low, no rx_tvalid is produced, and no partial data is kept.
- Divider: half-period counter div_cnt loads CLK_DIV-1 on every state entry. The state is left when div_cnt==0. Every timed state lasts exactly CLK_DIV cycles.
- Bit counter: width clog2(DATA_LEN)+1. Counts falling edges.
- State IDLE:
  - tx_tready = ~rx_tvalid.
  - On tx_tvalid & tx_tready: latch tx_tdata into the tx shift register, clear the rx shift register and bit count, set busy=1, tx_tready=0, and go to SETUP.
- State SETUP:
  - cs_n=0, mosi=tx_shift[MSB], sclk=0.
  - After CLK_DIV cycles: sclk←1, go to HIGH.
- State HIGH:
  - sclk=1.
  - After CLK_DIV cycles (falling edge): sclk←0, rx_shift←{rx_shift[DATA_LEN-2:0], spi_miso}, count+1.
  - If the new count == DATA_LEN, go to HOLD; else go to LOW.
- State LOW:
  - sclk=0.
  - After CLK_DIV cycles (rising edge): sclk←1, tx_shift←tx_shift<<1, mosi←next MSB, go to HIGH.
  - The first rising edge of a frame (SETUP→HIGH) never shifts.
- State HOLD:
  - sclk=0, cs_n=0.
  - After CLK_DIV cycles: cs_n←1, mosi←0, rx_tdata←rx_shift, rx_tvalid←1, go to GAP.
- State GAP:
  - cs_n=1.
  - After CLK_DIV cycles: busy←0, go to IDLE.
- Frame timing:
  - cs_n low time = CLK_DIV·(2·DATA_LEN+1) cycles, which is 68 at the defaults.
  - Exactly DATA_LEN rising and DATA_LEN falling sclk edges per frame.
  - Accept-to-cs_n-low latency = 1 cycle.
  - Accept-to-rx_tvalid = CLK_DIV·(2·DATA_LEN+1)+1 cycles.
  - Minimum frame-to-frame cs_n high time = CLK_DIV cycles.
- RX handshake: rx_tvalid stays high and rx_tdata stays stable until rx_tready=1 is sampled. rx_tvalid clears the following cycle.
- No overrun: a new frame cannot start while rx_tvalid=1, because tx_tready=0.
- Same-cycle events: if rx_tready and tx_tvalid are both high in IDLE with rx_tvalid=1, rx is consumed that cycle and tx is accepted on the next cycle.
- MISO sampling: miso is sampled only at falling edges. miso transitions at other times have no effect.

Test Plan:
- Loopback (miso=mosi), DATA_LEN=8, CLK_DIV=4, send 0xA5 → mosi bits 1,0,1,0,0,1,0,1 at rising edges; cs_n low 68 cycles; rx_tdata=0xA5; rx_tvalid 69 cycles after accept.
- Against spi_slave (slave clk = master clk, CLK_DIV=8), master sends 0xC3 while the slave transmits 0x3C → slave rx_tdata=0xC3, master rx_tdata=0x3C.
- Backpressure: rx_tready=0 after frame 1 (0x11) while tx_tvalid stays high with 0x22 → tx_tready=0 and cs_n stays high. Raise rx_tready → 0x11 is consumed; 0x22 is accepted on the next cycle and frame 2 starts.
- Back-to-back: tx_tvalid held with 0x01,0x02,0x03 and rx_tready=1 → three frames; cs_n high exactly 4 cycles between frames; rx sequence 0x01,0x02,0x03 (loopback).
- Reset mid-frame: assert rst after the 3rd falling edge → next cycle cs_n=1, sclk=0, mosi=0, tx_tready=1, busy=0; no rx_tvalid; the following frame 0x5A completes correctly.
- Width corner: DATA_LEN=16, CLK_DIV=2, loopback 0x8001 → rx 0x8001; cs_n low 66 cycles; 16 rising edges.
